sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 112 +++++++++++
 tb/tb_sum_accumulator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
//
// Adds up a block of COUNT_N unsigned 6-bit sums from the upstream adder stage
// into a 10-bit total. The block total is then held for the downstream consumer.
// The datapath cannot wrap because 16 x 62 = 992 fits in 10 bits.
//
// States:
//   IDLE  - count is 0 and the block is empty; new sums are accepted.
//   ACCUM - block partly filled; new sums are accepted and bubbles are allowed.
//   HOLD  - block complete; acc_valid=1 and nothing more is accepted until
//           out_ready is seen.
//
// Ports:
//   clk        in   single clock; all state changes on its rising edge
//   reset_n    in   asynchronous active-low reset
//   in_sum     in   [5:0] unsigned sum to accumulate
//   in_valid   in   in_sum is valid this cycle
//   in_ready   out  block accepts in_sum this cycle
//   clear      in   synchronous abort of the current block (highest priority)
//   out_ready  in   downstream consumes the completed total (used in HOLD only)
//   acc_out    out  [9:0] running or final total
//   acc_count  out  [4:0] number of sums accepted into the current block
//   acc_valid  out  acc_out holds a completed block total (high in HOLD)
// -----------------------------------------------------------------------------
module sum_accumulator #(
  parameter int COUNT_N = 4  // sums per block, 1..16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] in_sum,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clear,
  input  logic       out_ready,
  output logic [9:0] acc_out,
  output logic [4:0] acc_count,
  output logic       acc_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // This count value means the next accept completes the block.
  localparam logic [4:0] LAST_IDX = 5'(COUNT_N - 1);

  state_t     r_state;
  logic [9:0] r_acc_out;
  logic [4:0] r_acc_count;
  logic       r_acc_valid;
  logic       w_accept;

  // NOTE: in_ready is combinational so that clear can block an accept in the
  // same cycle. It is also gated by reset_n, so the block never reports ready
  // while it is held in reset.
  assign in_ready = reset_n & ~clear & (r_state != HOLD);
  assign w_accept = in_valid & in_ready;

  // NOTE: all state uses non-blocking assignments. Every branch then reads the
  // values from before the edge, so the completion test below compares the
  // old count with LAST_IDX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_acc_out   <= '0;
      r_acc_count <= '0;
      r_acc_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_acc_out   <= '0;
      r_acc_count <= '0;
      r_acc_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_acc_out   <= r_acc_out + {4'b0000, in_sum};
            r_acc_count <= r_acc_count + 5'd1;
            if (r_acc_count == LAST_IDX) begin
              r_state     <= HOLD;
              r_acc_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_acc_out   <= '0;
            r_acc_count <= '0;
            r_acc_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_acc_out   <= '0;
          r_acc_count <= '0;
          r_acc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign acc_out   = r_acc_out;
  assign acc_count = r_acc_count;
  assign acc_valid = r_acc_valid;

endmodule

// File: tb/tb_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator
//
// Three instances of sum_accumulator share one set of inputs:
// COUNT_N = 4, 16 and 1. Each test selects the instance it checks.
// Every test first clears, so the other instances start from a known state.
// Expected outputs come from constant tables or from a small behavioural model.
// They are pushed to a queue when the inputs are driven. They are popped and
// compared one cycle later, after the DUT has updated.
// -----------------------------------------------------------------------------
module tb_sum_accumulator;

  logic       clk;
  logic       reset_n;
  logic [5:0] in_sum;
  logic       in_valid;
  logic       clear;
  logic       out_ready;

  logic       rdy   [3];
  logic [9:0] aout  [3];
  logic [4:0] acnt  [3];
  logic       aval  [3];

  sum_accumulator #(.COUNT_N(4)) u_n4 (
    .clk(clk), .reset_n(reset_n), .in_sum(in_sum), .in_valid(in_valid),
    .in_ready(rdy[0]), .clear(clear), .out_ready(out_ready),
    .acc_out(aout[0]), .acc_count(acnt[0]), .acc_valid(aval[0]));

  sum_accumulator #(.COUNT_N(16)) u_n16 (
    .clk(clk), .reset_n(reset_n), .in_sum(in_sum), .in_valid(in_valid),
    .in_ready(rdy[1]), .clear(clear), .out_ready(out_ready),
    .acc_out(aout[1]), .acc_count(acnt[1]), .acc_valid(aval[1]));

  sum_accumulator #(.COUNT_N(1)) u_n1 (
    .clk(clk), .reset_n(reset_n), .in_sum(in_sum), .in_valid(in_valid),
    .in_ready(rdy[2]), .clear(clear), .out_ready(out_ready),
    .acc_out(aout[2]), .acc_count(acnt[2]), .acc_valid(aval[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] out;
    logic [4:0] cnt;
    logic       val;
  } exp_t;

  typedef struct {
    logic       clr;
    logic       v;
    logic [5:0] sum;
    logic       ordy;
    logic       rdy;   // expected in_ready while these inputs are applied
    logic [9:0] out;   // expected outputs after the next edge
    logic [4:0] cnt;
    logic       val;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and check in_ready.
  // Push the expected outputs, then pop and compare them after the rising edge.
  task automatic step(input int sel, input logic clr, input logic v,
                      input logic [5:0] sum, input logic ordy, input logic exp_rdy,
                      input logic [9:0] e_out, input logic [4:0] e_cnt, input logic e_val);
    exp_t e;
    exp_t got;
    @(negedge clk);
    clear     = clr;
    in_valid  = v;
    in_sum    = sum;
    out_ready = ordy;
    #1;
    check($sformatf("in_ready[%0d]", sel), rdy[sel], exp_rdy);
    e.out = e_out; e.cnt = e_cnt; e.val = e_val;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      got = sb_q.pop_front();
      check($sformatf("acc_out[%0d]", sel),   aout[sel], got.out);
      check($sformatf("acc_count[%0d]", sel), acnt[sel], got.cnt);
      check($sformatf("acc_valid[%0d]", sel), aval[sel], got.val);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_out[%0d]", tag, i),   aout[i], 10'd0);
      check($sformatf("%s_cnt[%0d]", tag, i),   acnt[i], 5'd0);
      check($sformatf("%s_val[%0d]", tag, i),   aval[i], 1'b0);
    end
  endtask

  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cnt16;
    logic [9:0] tot16;
    logic       v;

    // Fill the table used by the COUNT_N=4 instance.
    //            clr  v   sum    ordy rdy  out     cnt   val
    tbl[0]  = '{1'b0,1'b1,6'd10,1'b0,1'b1,10'd10, 5'd1,1'b0};
    tbl[1]  = '{1'b0,1'b1,6'd20,1'b0,1'b1,10'd30, 5'd2,1'b0};
    tbl[2]  = '{1'b0,1'b1,6'd30,1'b0,1'b1,10'd60, 5'd3,1'b0};
    tbl[3]  = '{1'b0,1'b1,6'd2, 1'b0,1'b1,10'd62, 5'd4,1'b1};
    tbl[4]  = '{1'b0,1'b1,6'd7, 1'b0,1'b0,10'd62, 5'd4,1'b1};
    tbl[5]  = '{1'b0,1'b1,6'd7, 1'b0,1'b0,10'd62, 5'd4,1'b1};
    tbl[6]  = '{1'b0,1'b1,6'd7, 1'b0,1'b0,10'd62, 5'd4,1'b1};
    tbl[7]  = '{1'b0,1'b1,6'd7, 1'b0,1'b0,10'd62, 5'd4,1'b1};
    tbl[8]  = '{1'b0,1'b1,6'd7, 1'b0,1'b0,10'd62, 5'd4,1'b1};
    tbl[9]  = '{1'b0,1'b0,6'd0, 1'b1,1'b0,10'd0,  5'd0,1'b0};
    tbl[10] = '{1'b0,1'b1,6'd12,1'b0,1'b1,10'd12, 5'd1,1'b0};
    tbl[11] = '{1'b0,1'b0,6'd50,1'b1,1'b1,10'd12, 5'd1,1'b0};
    tbl[12] = '{1'b0,1'b1,6'd13,1'b0,1'b1,10'd25, 5'd2,1'b0};
    tbl[13] = '{1'b1,1'b1,6'd9, 1'b0,1'b0,10'd0,  5'd0,1'b0};
    tbl[14] = '{1'b0,1'b1,6'd63,1'b0,1'b1,10'd63, 5'd1,1'b0};
    tbl[15] = '{1'b0,1'b1,6'd63,1'b1,1'b1,10'd126,5'd2,1'b0};
    tbl[16] = '{1'b1,1'b0,6'd0, 1'b1,1'b0,10'd0,  5'd0,1'b0};

    reset_n = 1'b0; in_sum = '0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_in_ready", rdy[0], 1'b0);
    check_all_zero("reset");
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1 check("post_reset_in_ready", rdy[0], 1'b1);

    // Run the COUNT_N=4 table.
    foreach (tbl[i])
      step(0, tbl[i].clr, tbl[i].v, tbl[i].sum, tbl[i].ordy, tbl[i].rdy,
           tbl[i].out, tbl[i].cnt, tbl[i].val);

    // COUNT_N=1: one accept completes the block.
    step(2, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 10'd0, 5'd0, 1'b0);
    step(2, 1'b0, 1'b1, 6'd40, 1'b0, 1'b1, 10'd40, 5'd1, 1'b1);
    step(2, 1'b0, 1'b1, 6'd3,  1'b0, 1'b0, 10'd40, 5'd1, 1'b1);
    step(2, 1'b0, 1'b1, 6'd3,  1'b1, 1'b0, 10'd0,  5'd0, 1'b0);
    step(2, 1'b0, 1'b1, 6'd1,  1'b0, 1'b1, 10'd1,  5'd1, 1'b1);

    // COUNT_N=16: sixteen sums of 62 with random bubbles.
    step(1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 10'd0, 5'd0, 1'b0);
    cnt16 = 0;
    tot16 = '0;
    for (int k = 0; k < 200 && cnt16 < 16; k++) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        cnt16++;
        tot16 = tot16 + 10'd62;
      end
      step(1, 1'b0, v, 6'd62, 1'b0, 1'b1, tot16, 5'(cnt16), cnt16 == 16);
    end
    check("n16_final_out", aout[1], 10'd992);
    check("n16_final_cnt", acnt[1], 5'd16);
    check("n16_ready_in_hold", rdy[1], 1'b0);

    // Pulse reset between edges while instance 0 is mid-block and instance 2
    // is in HOLD.
    step(0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 10'd0, 5'd0, 1'b0);
    step(0, 1'b0, 1'b1, 6'd17, 1'b0, 1'b1, 10'd17, 5'd1, 1'b0);
    check("pre_pulse_n1_valid", aval[2], 1'b1);
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check_all_zero("pulse");
    check("pulse_in_ready", rdy[0], 1'b0);
    #1 reset_n = 1'b1;
    step(0, 1'b0, 1'b1, 6'd21, 1'b0, 1'b1, 10'd21, 5'd1, 1'b0);
    step(0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 10'd21, 5'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
